gps: RTL and testbench
======================

GPS -- requirements
Module: gps

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: reset is sampled only on the rising edge of sys_clk_50.
REQ-002 sys_clk_50  in  1  sole clock; all state updates on its rising edge.
REQ-003 gps_clk_fast  in  1  reserved. It is tied by the integrator to inverted sys_clk_50, SHALL NOT be used as a clock or in any logic, and has no function.
REQ-004 sync_rst_in  in  1  synchronous active-high reset.
REQ-005 sv_num  in  6  satellite PRN number; sampled once per round on the start cycle.
REQ-006 startRound  in  1  level input; a 0->1 transition starts a round.
REQ-007 ca_code  out  13  the round's 13 C/A chips; the first chip ends in bit 12.
REQ-008 p_code  out  128  the round's 128 P chips; the first chip ends in bit 127.
REQ-009 l_code  out  128  mixed code derived from ca_code and p_code.
REQ-010 l_code_valid  out  1  high when ca_code, p_code and l_code hold a completed round.

Function
REQ-011 A registered copy of startRound SHALL detect the rising edge; the edge is acted on only in IDLE and is ignored while a round is busy.
REQ-012 States: IDLE -> GEN on the edge. GEN -> MIX after 128 GEN cycles. MIX -> DONE after 16 MIX cycles. DONE -> GEN on the next edge.
REQ-013 On the edge: sv_num is latched; ca_code, p_code, l_code and l_code_valid are cleared; the chip counter is set to 0.
REQ-014 C/A generation: G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10, both 10-bit Fibonacci LFSRs.
REQ-015 C/A chip = G1[10] xor (G2[ta] xor G2[tb]), with the tap pair per IS-GPS-200 table for PRN 1..32 (e.g. PRN1 = 2,6; PRN12 = 5,6). sv_num 0 or >32 SHALL use the PRN1 taps.
REQ-016 During GEN cycles 0..12, one C/A chip SHALL be produced per cycle: ca_code <= {ca_code[11:0], chip}, then G1 and G2 advance. G1/G2 hold otherwise.
REQ-017 P generation: X1 = 12-bit LFSR, x^12+x^11+x^8+x^6+1; X2 = 12-bit LFSR, x^12+x^11+x^10+x^9+x^8+x^5+x^2+x+1.
REQ-018 A 64-bit history H shifts in the X2 output each GEN cycle.
REQ-019 P chip = X1 out xor (sv_num==0 ? X2 out : H[sv_num-1]).
REQ-020 During all 128 GEN cycles: p_code <= {p_code[126:0], chip}, then X1, X2 and H advance.
REQ-021 LFSR and H state SHALL persist across rounds; only reset re-initialises it.
REQ-022 MIX: K = low 128 bits of ca_code replicated 10 times. State s starts at p_code xor K.
REQ-023 Each MIX round i (0..15): s <= rotl(s,5) xor K xor {120'b0, i[7:0]}.
REQ-024 After the 16th MIX round: l_code <= s and l_code_valid <= 1. l_code_valid is therefore first high 145 rising edges after the edge that detects startRound.
REQ-025 Outputs SHALL hold in DONE until the next start edge or reset.

Reset
REQ-026 Reset SHALL set: all outputs to 0, state to IDLE, G1 and G2 to all ones, X1 to 12'h248, X2 to 12'h925, H and s to 0, and the edge register to 1 so that a startRound already high at reset release does not start a round.
REQ-027 Reset SHALL override everything, including a mid-round reset: the block returns to IDLE with no valid output.

Verification
REQ-028 Reset, sv_num=1, startRound 0->1 -> 145 edges later l_code_valid=1 and ca_code[12:3]=10'b1100100000 (PRN1 octal 1440).
REQ-029 Reset, sv_num=12, startRound held high (as in the system bench) -> exactly one round; l_code_valid stays 1; outputs stable thereafter.
REQ-030 startRound toggled 0->1 while in GEN -> ignored; completion timing unchanged.
REQ-031 Reset asserted at GEN cycle 60 -> all outputs 0, l_code_valid 0. A new edge then reproduces the post-reset round bit-for-bit.
REQ-032 Two back-to-back rounds with the same sv_num -> second ca_code and p_code differ from the first because LFSR state continues.
REQ-033 sv_num=0 and sv_num=40 -> ca_code equals the PRN1 C/A sequence. p_code matches a reference model using delay 0 and delay 40 respectively.

Source files
------------

// File: rtl/gps.sv
// GPS code generator: per round, 13 C/A chips (G1/G2 Gold code), 128 P chips
// (X1/X2 LFSRs with a delayed X2 tap from a 64-bit history), then a 16-round
// rotate/xor mix of both into l_code. LFSR and history state carry over between
// rounds and are re-initialised only by reset.
module gps (
  input  logic         sys_clk_50,
  input  logic         gps_clk_fast,
  input  logic         sync_rst_in,
  input  logic [5:0]   sv_num,
  input  logic         startRound,
  output logic [12:0]  ca_code,
  output logic [127:0] p_code,
  output logic [127:0] l_code,
  output logic         l_code_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           start_prev_q, start_prev_d;
  logic           start_pulse_q, start_pulse_d;
  logic [5:0]     sv_q, sv_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [9:0]     g1_q, g1_d;
  logic [9:0]     g2_q, g2_d;
  logic [11:0]    x1_q, x1_d;
  logic [11:0]    x2_q, x2_d;
  logic [63:0]    h_q, h_d;
  logic [127:0]   s_q, s_d;
  logic [12:0]    ca_q, ca_d;
  logic [127:0]   p_q, p_d;
  logic [127:0]   l_q, l_d;
  logic           valid_q, valid_d;

  logic [3:0]     tap_a, tap_b;
  logic           g1_fb, g2_fb, x1_fb, x2_fb;
  logic           ca_chip, p_chip, p_delayed;
  logic [127:0]   k_word, mix_in, mix_out;

  // Reserved input: tied off by the integrator, deliberately not used.
  logic unused_clk_fast;
  assign unused_clk_fast = gps_clk_fast;

  // G2 phase-select tap pair for the latched PRN (1-based stage numbers).
  always_comb begin
    tap_a = 4'd2;
    tap_b = 4'd6;
    case (sv_q)
      6'd1:  begin tap_a = 4'd2; tap_b = 4'd6;  end
      6'd2:  begin tap_a = 4'd3; tap_b = 4'd7;  end
      6'd3:  begin tap_a = 4'd4; tap_b = 4'd8;  end
      6'd4:  begin tap_a = 4'd5; tap_b = 4'd9;  end
      6'd5:  begin tap_a = 4'd1; tap_b = 4'd9;  end
      6'd6:  begin tap_a = 4'd2; tap_b = 4'd10; end
      6'd7:  begin tap_a = 4'd1; tap_b = 4'd8;  end
      6'd8:  begin tap_a = 4'd2; tap_b = 4'd9;  end
      6'd9:  begin tap_a = 4'd3; tap_b = 4'd10; end
      6'd10: begin tap_a = 4'd2; tap_b = 4'd3;  end
      6'd11: begin tap_a = 4'd3; tap_b = 4'd4;  end
      6'd12: begin tap_a = 4'd5; tap_b = 4'd6;  end
      6'd13: begin tap_a = 4'd6; tap_b = 4'd7;  end
      6'd14: begin tap_a = 4'd7; tap_b = 4'd8;  end
      6'd15: begin tap_a = 4'd8; tap_b = 4'd9;  end
      6'd16: begin tap_a = 4'd9; tap_b = 4'd10; end
      6'd17: begin tap_a = 4'd1; tap_b = 4'd4;  end
      6'd18: begin tap_a = 4'd2; tap_b = 4'd5;  end
      6'd19: begin tap_a = 4'd3; tap_b = 4'd6;  end
      6'd20: begin tap_a = 4'd4; tap_b = 4'd7;  end
      6'd21: begin tap_a = 4'd5; tap_b = 4'd8;  end
      6'd22: begin tap_a = 4'd6; tap_b = 4'd9;  end
      6'd23: begin tap_a = 4'd1; tap_b = 4'd3;  end
      6'd24: begin tap_a = 4'd4; tap_b = 4'd6;  end
      6'd25: begin tap_a = 4'd5; tap_b = 4'd7;  end
      6'd26: begin tap_a = 4'd6; tap_b = 4'd8;  end
      6'd27: begin tap_a = 4'd7; tap_b = 4'd9;  end
      6'd28: begin tap_a = 4'd8; tap_b = 4'd10; end
      6'd29: begin tap_a = 4'd1; tap_b = 4'd6;  end
      6'd30: begin tap_a = 4'd2; tap_b = 4'd7;  end
      6'd31: begin tap_a = 4'd3; tap_b = 4'd8;  end
      6'd32: begin tap_a = 4'd4; tap_b = 4'd9;  end
      default: begin tap_a = 4'd2; tap_b = 4'd6; end
    endcase
  end

  // Chip and feedback terms. Bit n of each LFSR holds stage n+1; stage 1 takes
  // the feedback and the highest stage is the output.
  always_comb begin
    g1_fb     = g1_q[2] ^ g1_q[9];
    g2_fb     = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];
    x1_fb     = x1_q[11] ^ x1_q[10] ^ x1_q[7] ^ x1_q[5];
    x2_fb     = x2_q[11] ^ x2_q[10] ^ x2_q[9] ^ x2_q[8] ^ x2_q[7] ^ x2_q[4]
              ^ x2_q[1] ^ x2_q[0];
    ca_chip   = g1_q[9] ^ g2_q[tap_a - 4'd1] ^ g2_q[tap_b - 4'd1];
    p_delayed = (sv_q == '0) ? x2_q[11] : h_q[sv_q - 6'd1];
    p_chip    = x1_q[11] ^ p_delayed;
  end

  // Mix datapath: K is the low 128 bits of ten copies of ca_code. The first
  // round takes p_code^K directly as its input so no separate seed cycle is spent.
  always_comb begin
    k_word  = {ca_q[10:0], {9{ca_q}}};
    mix_in  = (cnt_q == '0) ? (p_q ^ k_word) : s_q;
    mix_out = {mix_in[122:0], mix_in[127:123]} ^ k_word ^ {121'd0, cnt_q};
  end

  // Next-state: edge detect, round sequencing and code generation.
  always_comb begin
    state_d       = state_q;
    start_prev_d  = startRound;
    start_pulse_d = startRound & ~start_prev_q;
    sv_d          = sv_q;
    cnt_d         = cnt_q;
    g1_d          = g1_q;
    g2_d          = g2_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    h_d           = h_q;
    s_d           = s_q;
    ca_d          = ca_q;
    p_d           = p_q;
    l_d           = l_q;
    valid_d       = valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_pulse_q) begin
          state_d = GEN;
          sv_d    = sv_num;
          cnt_d   = '0;
          ca_d    = '0;
          p_d     = '0;
          l_d     = '0;
          valid_d = 1'b0;
        end
      end
      GEN: begin
        if (cnt_q < 7'd13) begin
          ca_d = {ca_q[11:0], ca_chip};
          g1_d = {g1_q[8:0], g1_fb};
          g2_d = {g2_q[8:0], g2_fb};
        end
        p_d  = {p_q[126:0], p_chip};
        x1_d = {x1_q[10:0], x1_fb};
        x2_d = {x2_q[10:0], x2_fb};
        h_d  = {h_q[62:0], x2_q[11]};
        if (cnt_q == 7'd127) begin
          state_d = MIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      MIX: begin
        s_d = mix_out;
        if (cnt_q == 7'd15) begin
          state_d = DONE;
          cnt_d   = '0;
          l_d     = mix_out;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge sys_clk_50) begin
    if (sync_rst_in) begin
      state_q       <= IDLE;
      start_prev_q  <= 1'b1;
      start_pulse_q <= 1'b0;
      sv_q          <= '0;
      cnt_q         <= '0;
      g1_q          <= '1;
      g2_q          <= '1;
      x1_q          <= 12'h248;
      x2_q          <= 12'h925;
      h_q           <= '0;
      s_q           <= '0;
      ca_q          <= '0;
      p_q           <= '0;
      l_q           <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_prev_d;
      start_pulse_q <= start_pulse_d;
      sv_q          <= sv_d;
      cnt_q         <= cnt_d;
      g1_q          <= g1_d;
      g2_q          <= g2_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
      h_q           <= h_d;
      s_q           <= s_d;
      ca_q          <= ca_d;
      p_q           <= p_d;
      l_q           <= l_d;
      valid_q       <= valid_d;
    end
  end

  assign ca_code      = ca_q;
  assign p_code       = p_q;
  assign l_code       = l_q;
  assign l_code_valid = valid_q;

endmodule

// File: tb/tb_gps.sv
// Scoreboard bench for gps: each started round pushes its expected codes and
// completion cycle, computed by a stage-array reference model; a monitor pops
// and compares on every rising edge of l_code_valid.
module tb_gps;

  typedef struct {
    logic [12:0]  ca;
    logic [127:0] p;
    logic [127:0] l;
    int unsigned  due;
  } exp_t;

  logic         clk = 1'b0;
  logic         gps_clk_fast;
  logic         rst;
  logic         start;
  logic [5:0]   sv;
  logic [12:0]  ca;
  logic [127:0] pc;
  logic [127:0] lc;
  logic         vld;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  int unsigned  cyc = 0;
  exp_t         exp_q[$];
  exp_t         last_e;

  // Reference model state: stage arrays, stage 1 = newest, top stage = output.
  bit mg1[1:10];
  bit mg2[1:10];
  bit mx1[1:12];
  bit mx2[1:12];
  bit hist[$];
  int TAP_A[1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int TAP_B[1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  always #10 clk = ~clk;
  assign gps_clk_fast = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gps dut (
    .sys_clk_50   (clk),
    .gps_clk_fast (gps_clk_fast),
    .sync_rst_in  (rst),
    .sv_num       (sv),
    .startRound   (start),
    .ca_code      (ca),
    .p_code       (pc),
    .l_code       (lc),
    .l_code_valid (vld)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    logic [11:0] v1;
    logic [11:0] v2;
    v1 = 12'h248;
    v2 = 12'h925;
    for (int k = 1; k <= 10; k++) begin mg1[k] = 1'b1; mg2[k] = 1'b1; end
    for (int k = 1; k <= 12; k++) begin mx1[k] = v1[k-1]; mx2[k] = v2[k-1]; end
    hist.delete();
    for (int k = 0; k < 64; k++) hist.push_back(1'b0);
  endtask

  task automatic model_round(input int s, output exp_t e);
    int prn;
    bit chip, fb, x2o, pchip;
    logic [127:0] k, st;
    prn  = (s >= 1 && s <= 32) ? s : 1;
    e.ca = '0;
    e.p  = '0;
    for (int c = 0; c < 128; c++) begin
      if (c < 13) begin
        chip = mg1[10] ^ mg2[TAP_A[prn]] ^ mg2[TAP_B[prn]];
        e.ca = {e.ca[11:0], chip};
        fb = mg1[3] ^ mg1[10];
        for (int j = 10; j > 1; j--) mg1[j] = mg1[j-1];
        mg1[1] = fb;
        fb = mg2[2] ^ mg2[3] ^ mg2[6] ^ mg2[8] ^ mg2[9] ^ mg2[10];
        for (int j = 10; j > 1; j--) mg2[j] = mg2[j-1];
        mg2[1] = fb;
      end
      x2o   = mx2[12];
      pchip = mx1[12] ^ ((s == 0) ? x2o : hist[s-1]);
      e.p   = {e.p[126:0], pchip};
      fb = mx1[12] ^ mx1[11] ^ mx1[8] ^ mx1[6];
      for (int j = 12; j > 1; j--) mx1[j] = mx1[j-1];
      mx1[1] = fb;
      fb = mx2[12] ^ mx2[11] ^ mx2[10] ^ mx2[9] ^ mx2[8] ^ mx2[5] ^ mx2[2] ^ mx2[1];
      for (int j = 12; j > 1; j--) mx2[j] = mx2[j-1];
      mx2[1] = fb;
      hist.push_front(x2o);
      void'(hist.pop_back());
    end
    for (int j = 0; j < 128; j++) k[j] = e.ca[j % 13];
    st = e.p ^ k;
    for (int i = 0; i < 16; i++) st = ((st << 5) | (st >> 123)) ^ k ^ 128'(i);
    e.l   = st;
    e.due = 0;
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  initial begin : monitor
    logic vprev;
    exp_t e;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && vld && !vprev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got l_code_valid rise at cycle %0d, required none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("ca_code", 128'(ca), 128'(e.ca));
          check("p_code", pc, e.p);
          check("l_code", lc, e.l);
          check("latency", 128'(cyc), 128'(e.due));
          last_e = e;
        end
      end
      vprev = vld;
    end
  end

  task automatic do_reset(input logic start_level);
    @(negedge clk);
    rst   = 1'b1;
    start = start_level;
    repeat (3) @(negedge clk);
    exp_q.delete();
    model_reset();
    rst = 1'b0;
  endtask

  task automatic start_round(input int s, output exp_t e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sv    = 6'(s);
    start = 1'b1;
    model_round(s, e);
    e.due = cyc + 146;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL round_timeout: got %0d rounds pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 128'(vld), 128'(0));
    check({tag, "_ca"}, 128'(ca), 128'(0));
    check({tag, "_p"}, pc, '0);
    check({tag, "_l"}, lc, '0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e, first_e, abort_e;
    int s;
    rst   = 1'b1;
    start = 1'b0;
    sv    = '0;
    model_reset();

    // startRound already high at reset release must not start a round.
    do_reset(1'b1);
    @(negedge clk);
    check_zero("reset");
    repeat (200) @(negedge clk);
    check("no_round_held_high", 128'(vld), 128'(0));

    // PRN1 after reset: first ten chips are octal 1440.
    do_reset(1'b0);
    start_round(1, first_e);
    wait_done();
    check("prn1_first10", 128'(ca[12:3]), 128'(10'b1100100000));

    // Back-to-back same PRN: LFSR state carries on, so codes differ.
    start_round(1, e);
    wait_done();
    check("b2b_ca_differs", 128'(ca != first_e.ca), 128'(1));
    check("b2b_p_differs", 128'(pc != first_e.p), 128'(1));

    // PRN12 with startRound held high: one round only, outputs stay put.
    do_reset(1'b0);
    start_round(12, e);
    wait_done();
    repeat (300) @(negedge clk);
    check("hold_valid", 128'(vld), 128'(1));
    check("hold_ca", 128'(ca), 128'(e.ca));
    check("hold_p", pc, e.p);
    check("hold_l", lc, e.l);

    // Re-toggle during GEN is ignored; completion time is still checked.
    start_round(7, e);
    repeat (20) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done();

    // Reset at GEN cycle 60, then replay must match the aborted expectation.
    do_reset(1'b0);
    start_round(5, abort_e);
    repeat (61) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    start_round(5, e);
    wait_done();
    check("replay_p", pc, abort_e.p);
    check("replay_l", lc, abort_e.l);

    // Out-of-table PRNs fall back to PRN1 C/A taps; P uses delay 0 / 40.
    do_reset(1'b0);
    start_round(0, e);
    wait_done();
    check("prn0_ca", 128'(ca), 128'(first_e.ca));
    do_reset(1'b0);
    start_round(40, e);
    wait_done();
    check("prn40_ca", 128'(ca), 128'(first_e.ca));

    // Random PRNs with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 63));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      start_round(s, e);
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
